// File: rtl/filtro_pkg.sv
// Shared definitions for the IIR filter sequencer: FSM states, datapath mux
// indices and the per-state microprogram table.
package filtro_pkg;

    typedef enum logic [2:0] {
        IDLE,
        P0,
        P1,
        P2,
        P3,
        P4,
        P5,
        LISTO
    } estado_t;

    // Constant-mux indices
    localparam logic [2:0] C_A1   = 3'd0;
    localparam logic [2:0] C_A2   = 3'd1;
    localparam logic [2:0] C_CERO = 3'd2;
    localparam logic [2:0] C_B0   = 3'd3;
    localparam logic [2:0] C_B1   = 3'd4;
    localparam logic [2:0] C_B2   = 3'd5;

    // fk-mux indices
    localparam logic [1:0] F_K  = 2'd0;
    localparam logic [1:0] F_K1 = 2'd1;
    localparam logic [1:0] F_K2 = 2'd2;

    // Strobe mask bits: {Acum_En, Acum_Clr, Shift_En}
    localparam logic [2:0] M_NADA  = 3'b000;
    localparam logic [2:0] M_EN    = 3'b100;
    localparam logic [2:0] M_CLR   = 3'b010;
    localparam logic [2:0] M_SHIFT = 3'b001;

    typedef struct packed {
        logic [2:0] sel_const;
        logic [1:0] sel_fk;
        logic       sel_acum;
        logic [2:0] mascara;
    } micro_t;

    // Microprogram: selects for each state plus the strobes fired at step end.
    // IDLE and LISTO share the idle decode (no strobes, Yk held).
    function automatic micro_t micro_paso(input estado_t e);
        micro_t m;
        case (e)
            P0:      m = micro_t'{C_A1,   F_K1, 1'b0, M_EN};
            P1:      m = micro_t'{C_A2,   F_K2, 1'b1, M_EN};
            P2:      m = micro_t'{C_CERO, F_K,  1'b1, M_SHIFT | M_CLR};
            P3:      m = micro_t'{C_B0,   F_K,  1'b1, M_EN};
            P4:      m = micro_t'{C_B1,   F_K1, 1'b1, M_EN};
            P5:      m = micro_t'{C_B2,   F_K2, 1'b1, M_EN};
            default: m = micro_t'{C_CERO, F_K,  1'b1, M_NADA};
        endcase
        return m;
    endfunction

endpackage

// File: rtl/detector_flanco.sv
// Registered rising-edge detector. The history register resets to 1 so a
// level already high when reset is released is not seen as an edge.
module detector_flanco (
    input  logic Clk,
    input  logic Reset_n,
    input  logic In,
    output logic Pulso
);

    logic r_prev;

    // Remember the input level from the previous cycle
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= In;
        end
    end

    assign Pulso = In & ~r_prev;

endmodule

// File: rtl/secuenciador_filtro_iir.sv
// Sequencer for the 2nd-order IIR low-pass datapath. Each new ADC sample
// runs a 6-step microprogram (P0..P5), each step ESPERA+1 cycles long, then
// pulses Bandera_Listo for one cycle.
// Optional macro SECUENCIADOR_PENDIENTE_EN: a one-deep pending flag queues a
// sample arriving while busy instead of flagging an overrun.
module secuenciador_filtro_iir
    import filtro_pkg::*;
#(
    parameter int unsigned ESPERA   = 0,
    parameter int unsigned ESPERA_W = 4
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Bandera_ADC,
    input  logic       Borrar_Error,
    output logic [2:0] Sel_Const,
    output logic [1:0] Sel_Fk,
    output logic       Sel_Acum,
    output logic       Acum_En,
    output logic       Acum_Clr,
    output logic       Shift_En,
    output logic       Bandera_Listo,
    output logic       Ocupado,
    output logic       Error_Sobrecarga
);

    estado_t               r_estado;
    estado_t               w_estado_sig;
    logic [ESPERA_W-1:0]   r_espera;
    logic                  r_error;
    logic                  w_inicio;
    logic                  w_ocupado;
    logic                  w_ultimo;
    logic                  w_sobrecarga;
    logic                  w_arranque_listo;
    micro_t                w_micro;
    logic [2:0]            w_strobe;

    detector_flanco u_detector (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .In      (Bandera_ADC),
        .Pulso   (w_inicio)
    );

    assign w_ocupado = (r_estado != IDLE) && (r_estado != LISTO);
    assign w_ultimo  = (r_espera == ESPERA_W'(ESPERA));

`ifdef SECUENCIADOR_PENDIENTE_EN
    logic r_pendiente;

    // Queue one busy-time sample; consumed (and cleared) in LISTO
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pendiente <= 1'b0;
        end else if (r_estado == LISTO) begin
            r_pendiente <= 1'b0;
        end else if (w_inicio && w_ocupado) begin
            r_pendiente <= 1'b1;
        end
    end

    assign w_sobrecarga     = w_inicio & w_ocupado & r_pendiente;
    assign w_arranque_listo = w_inicio | r_pendiente;
`else
    assign w_sobrecarga     = w_inicio & w_ocupado;
    assign w_arranque_listo = w_inicio;
`endif

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_estado <= IDLE;
        end else begin
            r_estado <= w_estado_sig;
        end
    end

    // Next-state logic: steps advance when the wait counter reaches ESPERA
    always_comb begin
        w_estado_sig = r_estado;
        case (r_estado)
            IDLE:    if (w_inicio) w_estado_sig = P0;
            P0:      if (w_ultimo) w_estado_sig = P1;
            P1:      if (w_ultimo) w_estado_sig = P2;
            P2:      if (w_ultimo) w_estado_sig = P3;
            P3:      if (w_ultimo) w_estado_sig = P4;
            P4:      if (w_ultimo) w_estado_sig = P5;
            P5:      if (w_ultimo) w_estado_sig = LISTO;
            LISTO:   w_estado_sig = w_arranque_listo ? P0 : IDLE;
            default: w_estado_sig = IDLE;
        endcase
    end

    // Wait counter: counts within a step, clears on every step change
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_espera <= '0;
        end else if (!w_ocupado || (w_estado_sig != r_estado)) begin
            r_espera <= '0;
        end else begin
            r_espera <= r_espera + 1'b1;
        end
    end

    // Sticky overrun flag; a set wins over a simultaneous clear
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_error <= 1'b0;
        end else if (w_sobrecarga) begin
            r_error <= 1'b1;
        end else if (Borrar_Error) begin
            r_error <= 1'b0;
        end
    end

    // Output decode of state and wait counter; strobes only in a step's last cycle
    always_comb begin
        w_micro          = micro_paso(r_estado);
        w_strobe         = (w_ocupado && w_ultimo) ? w_micro.mascara : M_NADA;
        Sel_Const        = w_micro.sel_const;
        Sel_Fk           = w_micro.sel_fk;
        Sel_Acum         = w_micro.sel_acum;
        Acum_En          = w_strobe[2];
        Acum_Clr         = w_strobe[1];
        Shift_En         = w_strobe[0];
        Bandera_Listo    = (r_estado == LISTO);
        Ocupado          = w_ocupado;
        Error_Sobrecarga = r_error;
    end

endmodule

// File: doc/secuenciador_filtro_iir.md
Name: secuenciador_filtro_iir

Overview:
- Sequencer for the 2nd-order IIR low-pass datapath: constant mux, uk/accumulator mux, fk mux, multiply-add, fk shift register, accumulator.
- On each new ADC sample it steps the datapath through a fixed 6-step microprogram, then pulses Bandera_Listo.
- Handles ADC handshake timing, multi-cycle arithmetic stretch, and overrun detection.
- Sits between the ADC interface and the filter datapath.

Parameters:
- ESPERA, 0, extra wait cycles per microprogram step (each step lasts ESPERA+1 cycles).
- ESPERA_W, 4, width of the wait counter; ESPERA < 2**ESPERA_W.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- Bandera_ADC  in  1  new-sample flag, level, synchronous to Clk; start on rising edge.
- Borrar_Error  in  1  synchronous clear of Error_Sobrecarga.
- Sel_Const  out  3  constant-mux index: 0=-a1, 1=-a2, 2=zero, 3=b0, 4=b1, 5=b2.
- Sel_Fk  out  2  fk-mux index: 0=fk, 1=fk_1, 2=fk_2.
- Sel_Acum  out  1  0 = adder input from Uk, 1 = from accumulator.
- Acum_En  out  1  accumulator load strobe.
- Acum_Clr  out  1  accumulator synchronous clear strobe; has priority over Acum_En.
- Shift_En  out  1  fk shift-register shift strobe.
- Bandera_Listo  out  1  one-cycle pulse: Yk valid.
- Ocupado  out  1  high in states P0..P5.
- Error_Sobrecarga  out  1  sticky overrun flag.

Behaviour:
- States: IDLE, P0..P5, LISTO. Outputs are a decode of the registered state and wait counter.
- Edge detect: a register holds Bandera_ADC from the previous cycle.
  - inicio = Bandera_ADC & ~prev.
  - prev resets to 1, so a flag already high at reset release does not start a sample.
- Microprogram. Selects are held for the whole step; strobes assert only in the last cycle of the step (wait counter = ESPERA).
  - P0: Const 0, Fk 1, Acum 0, Acum_En. Result: acc = Uk - a1*fk_1.
  - P1: Const 1, Fk 2, Acum 1, Acum_En. Result: acc = fk (new).
  - P2: Const 2, Fk 0, Acum 1, Shift_En, Acum_Clr. Shift register captures 0*x + acc = fk; acc cleared to 0.
  - P3: Const 3, Fk 0, Acum 1, Acum_En.
  - P4: Const 4, Fk 1, Acum 1, Acum_En.
  - P5: Const 5, Fk 2, Acum 1, Acum_En. Result: acc = Yk.
  - LISTO: one cycle; Bandera_Listo=1; all strobes 0, so Yk is held.
- Idle/reset output values: Sel_Const=2, Sel_Fk=0, Sel_Acum=1, all strobes 0, Bandera_Listo=0, Ocupado=0, Error_Sobrecarga=0.
- Transitions:
  - IDLE -> P0 on inicio.
  - Pk -> Pk+1 when wait counter = ESPERA; the counter clears on every step change.
  - P5 -> LISTO.
  - LISTO -> P0 if inicio that cycle, else IDLE.
- Latency: inicio sampled at edge t puts the FSM in P0 for cycle t+1. Bandera_Listo is high in cycle t+1+6*(ESPERA+1).
- Overrun: inicio while Ocupado=1 sets Error_Sobrecarga. The sample is dropped and the sequence is unaffected.
- Borrar_Error clears the flag on the next edge. A set and a clear in the same cycle resolve to set.
- Reset mid-sequence: asynchronous return to IDLE with idle outputs. The partial sample is discarded; the datapath registers are not touched by this block.

Optional Feature:
- Macro SECUENCIADOR_PENDIENTE_EN.
- Defined:
  - A one-deep pending flag latches inicio seen while Ocupado=1; no error is raised.
  - LISTO then goes to P0 if inicio or the pending flag is set, and the pending flag clears.
  - A further inicio while the pending flag is already set raises Error_Sobrecarga.
  - Reset clears the pending flag.
- Undefined: every busy inicio is dropped and raises Error_Sobrecarga, as described in Behaviour.

Decomposition:
- Package filtro_pkg holds:
  - the state enum;
  - constant-index localparams (C_A1=0, C_A2=1, C_CERO=2, C_B0=3, C_B1=4, C_B2=5);
  - fk-index localparams;
  - the microprogram table (per state: Sel_Const, Sel_Fk, Sel_Acum, strobe mask).
- One sub-module: detector_flanco (registered rising-edge detector, reset value 1, ports Clk/Reset_n/In/Pulso).

Test Plan:
- ESPERA=0; Bandera_ADC 0->1 at cycle 10 -> P0..P5 in cycles 11-16 with the exact select/strobe table; Bandera_Listo=1 only at cycle 17; Shift_En and Acum_Clr high only at cycle 13.
- ESPERA=2 -> each select held 3 cycles; each strobe high only in the 3rd cycle of its step; Bandera_Listo at cycle 11+18=29.
- Bandera_ADC held high through reset release -> no start; a later 0->1 starts normally.
- Second rising edge during P3 -> Error_Sobrecarga=1, exactly one Bandera_Listo pulse. Borrar_Error with no new overrun clears the flag; Borrar_Error together with an overrun leaves it 1. With SECUENCIADOR_PENDIENTE_EN: no error, and a second sequence starts the cycle after LISTO.
- Rising edge coincident with LISTO -> P0 on the next cycle, no error, back-to-back Listo pulses 7 cycles apart.
- Reset_n asserted during P4 -> outputs go to idle values immediately (asynchronously); after release the FSM is in IDLE with no Bandera_Listo.
